// File: rtl/phase_decoder_pkg.sv
// -----------------------------------------------------------------------------
// phase_decoder_pkg
// Shared types and helpers for the phase decoder.
//   state_t        : decoder state (HUNT, LOCKING, LOCKED)
//   sample_class_t : classification of a registered phase sample
//   idx_width()    : width of a phase index for an N-phase vector (min 1)
// -----------------------------------------------------------------------------
package phase_decoder_pkg;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    LOCKING = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    INVALID = 2'd0,
    HOLD    = 2'd1,
    ADVANCE = 2'd2,
    SKIP    = 2'd3
  } sample_class_t;

  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/phase_decoder_onehot_index.sv
// -----------------------------------------------------------------------------
// onehot_index
// Combinational one-hot decoder.
//   vector : NUM_PHASES-bit candidate one-hot vector
//   legal  : exactly one bit of vector is set
//   idx    : position of the set bit (meaningful only when legal)
// -----------------------------------------------------------------------------
module onehot_index
  import phase_decoder_pkg::*;
#(
  parameter int NUM_PHASES = 3,
  parameter int IDX_W      = idx_width(NUM_PHASES)
) (
  input  logic [NUM_PHASES-1:0] vector,
  output logic                  legal,
  output logic [IDX_W-1:0]      idx
);

  always_comb begin
    legal = ($countones(vector) == 1);
    idx   = '0;
    for (int i = 0; i < NUM_PHASES; i++) begin
      if (vector[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/phase_decoder.sv
// -----------------------------------------------------------------------------
// phase_decoder
// Decodes the rotating one-hot phase vector of the multi-phase clock divider
// into a phase index, verifies legal one-hot, rotation order (bit k -> k-1,
// bit 0 wraps to NUM_PHASES-1) and bounded dwell, locks after LOCK_COUNT good
// advances and re-hunts after any error.
//   clkIn      : sampling clock, all state on rising edge
//   reset      : asynchronous active-high reset
//   phaseIn    : one-hot phase vector from the divider
//   phaseIdx   : index of the last legal, non-error sample
//   locked     : high while LOCKED
//   cycleStart : one-cycle pulse on a locked advance into index 0
//   phaseErr   : one-cycle pulse on a violation while LOCKED
// Optional (macro PHASE_DECODER_ERR_COUNT_EN):
//   errClr     : clears errCount (wins over a coincident error)
//   errCount   : saturating 8-bit count of phaseErr pulses
// -----------------------------------------------------------------------------
module phase_decoder
  import phase_decoder_pkg::*;
#(
  parameter int NUM_PHASES = 3,
  parameter int LOCK_COUNT = 4,
  parameter int TIMEOUT    = 4
) (
  input  logic                                clkIn,
  input  logic                                reset,
  input  logic [NUM_PHASES-1:0]               phaseIn,
  output logic [idx_width(NUM_PHASES)-1:0]    phaseIdx,
  output logic                                locked,
  output logic                                cycleStart,
  output logic                                phaseErr
`ifdef PHASE_DECODER_ERR_COUNT_EN
  ,
  input  logic                                errClr,
  output logic [7:0]                          errCount
`endif
);

  localparam int IDX_W   = idx_width(NUM_PHASES);
  localparam int GOOD_W  = $clog2(LOCK_COUNT + 1);
  localparam int DWELL_W = $clog2(TIMEOUT + 1);

  logic [NUM_PHASES-1:0] phase_q;
  state_t                state_q, state_d;
  logic [IDX_W-1:0]      lastIdx_q, lastIdx_d;
  logic [GOOD_W-1:0]     goodCnt_q, goodCnt_d;
  logic [DWELL_W-1:0]    dwell_q, dwell_d;
  logic                  cycleStart_q, cycleStart_d;
  logic                  phaseErr_q, phaseErr_d;

  logic                  sampleLegal;
  logic [IDX_W-1:0]      sampleIdx;
  logic [IDX_W-1:0]      advIdx;
  logic [GOOD_W-1:0]     goodInc;
  sample_class_t         cls;
  logic                  timeout;
  logic                  isErr;

  onehot_index #(
    .NUM_PHASES (NUM_PHASES),
    .IDX_W      (IDX_W)
  ) u_onehot_index (
    .vector (phase_q),
    .legal  (sampleLegal),
    .idx    (sampleIdx)
  );

  // The expected next index is one below the stored one, wrapping at zero.
  assign advIdx  = (lastIdx_q == '0) ? IDX_W'(NUM_PHASES - 1) : lastIdx_q - IDX_W'(1);
  assign goodInc = goodCnt_q + GOOD_W'(1);

  always_comb begin
    cls = SKIP;
    if (!sampleLegal)                cls = INVALID;
    else if (sampleIdx == lastIdx_q) cls = HOLD;
    else if (sampleIdx == advIdx)    cls = ADVANCE;
  end

  // A hold is only a timeout when it would push the dwell past TIMEOUT.
  assign timeout = (cls == HOLD) && (dwell_q == DWELL_W'(TIMEOUT));
  assign isErr   = (cls == INVALID) || (cls == SKIP) || timeout;

  always_comb begin
    state_d      = state_q;
    lastIdx_d    = lastIdx_q;
    goodCnt_d    = goodCnt_q;
    dwell_d      = dwell_q;
    cycleStart_d = 1'b0;
    phaseErr_d   = 1'b0;
    case (state_q)
      HUNT: begin
        // Any legal sample is accepted as the starting point; invalid ones are ignored.
        if (sampleLegal) begin
          lastIdx_d = sampleIdx;
          goodCnt_d = '0;
          dwell_d   = DWELL_W'(1);
          state_d   = LOCKING;
        end
      end
      LOCKING: begin
        if (isErr) begin
          state_d   = HUNT;
          goodCnt_d = '0;
          dwell_d   = '0;
        end else if (cls == ADVANCE) begin
          lastIdx_d = sampleIdx;
          dwell_d   = DWELL_W'(1);
          goodCnt_d = goodInc;
          if (goodInc == GOOD_W'(LOCK_COUNT)) state_d = LOCKED;
        end else begin
          dwell_d = dwell_q + DWELL_W'(1);
        end
      end
      LOCKED: begin
        if (isErr) begin
          phaseErr_d = 1'b1;
          state_d    = HUNT;
          goodCnt_d  = '0;
          dwell_d    = '0;
        end else if (cls == ADVANCE) begin
          lastIdx_d    = sampleIdx;
          dwell_d      = DWELL_W'(1);
          cycleStart_d = (sampleIdx == '0);
        end else begin
          dwell_d = dwell_q + DWELL_W'(1);
        end
      end
      default: state_d = HUNT;
    endcase
  end

  always_ff @(posedge clkIn or posedge reset) begin
    if (reset) begin
      phase_q      <= '0;
      state_q      <= HUNT;
      lastIdx_q    <= '0;
      goodCnt_q    <= '0;
      dwell_q      <= '0;
      cycleStart_q <= 1'b0;
      phaseErr_q   <= 1'b0;
    end else begin
      phase_q      <= phaseIn;
      state_q      <= state_d;
      lastIdx_q    <= lastIdx_d;
      goodCnt_q    <= goodCnt_d;
      dwell_q      <= dwell_d;
      cycleStart_q <= cycleStart_d;
      phaseErr_q   <= phaseErr_d;
    end
  end

  assign phaseIdx   = lastIdx_q;
  assign locked     = (state_q == LOCKED);
  assign cycleStart = cycleStart_q;
  assign phaseErr   = phaseErr_q;

`ifdef PHASE_DECODER_ERR_COUNT_EN
  logic [7:0] errCount_q, errCount_d;

  // Counts on the same edge that raises phaseErr; a clear always wins.
  always_comb begin
    errCount_d = errCount_q;
    if (errClr)                                  errCount_d = '0;
    else if (phaseErr_d && errCount_q != 8'hFF)  errCount_d = errCount_q + 8'd1;
  end

  always_ff @(posedge clkIn or posedge reset) begin
    if (reset) errCount_q <= '0;
    else       errCount_q <= errCount_d;
  end

  assign errCount = errCount_q;
`endif

endmodule

// File: tb/tb_phase_decoder.sv
// -----------------------------------------------------------------------------
// tb_phase_decoder
// Self-checking bench for phase_decoder: directed scenarios followed by
// randomized rotation with glitches, compared against a behavioural model.
// Build with PHASE_DECODER_ERR_COUNT_EN to also exercise errClr/errCount.
// -----------------------------------------------------------------------------
module tb_phase_decoder;
  import phase_decoder_pkg::*;

  localparam int N  = 3;
  localparam int LC = 4;
  localparam int TO = 4;
  localparam int IW = idx_width(N);

  logic          clkIn = 1'b0;
  logic          reset;
  logic [N-1:0]  phaseIn;
  logic [IW-1:0] phaseIdx;
  logic          locked;
  logic          cycleStart;
  logic          phaseErr;
`ifdef PHASE_DECODER_ERR_COUNT_EN
  logic          errClr;
  logic [7:0]    errCount;
`endif

  int checks   = 0;
  int failures = 0;

  // Behavioural model: "acquired" plus a run length of good advances.
  logic [N-1:0] m_q;
  bit           m_acq;
  int           m_run, m_dw, m_last, m_cnt;
  bit           m_err, m_cs;
  int           cur;

  always #5 clkIn = ~clkIn;

  phase_decoder #(
    .NUM_PHASES (N),
    .LOCK_COUNT (LC),
    .TIMEOUT    (TO)
  ) dut (
    .clkIn      (clkIn),
    .reset      (reset),
    .phaseIn    (phaseIn),
    .phaseIdx   (phaseIdx),
    .locked     (locked),
    .cycleStart (cycleStart),
    .phaseErr   (phaseErr)
`ifdef PHASE_DECODER_ERR_COUNT_EN
    ,
    .errClr     (errClr),
    .errCount   (errCount)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] oh(input int i);
    logic [N-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic model_reset();
    m_q = '0; m_acq = 0; m_run = 0; m_dw = 0; m_last = 0;
    m_cnt = 0; m_err = 0; m_cs = 0;
  endtask

  task automatic model_step(input logic [N-1:0] s, input bit clr);
    int idx;
    bit legal, bad;
    legal = ($countones(s) == 1);
    idx = 0;
    for (int i = 0; i < N; i++) if (s[i]) idx = i;
    m_err = 0;
    m_cs  = 0;
    if (!m_acq) begin
      if (legal) begin
        m_acq = 1; m_run = 0; m_dw = 1; m_last = idx;
      end
    end else begin
      bad = !legal
         || (idx != m_last && idx != (m_last + N - 1) % N)
         || (idx == m_last && m_dw + 1 > TO);
      if (bad) begin
        m_err = (m_run >= LC);
        m_acq = 0;
      end else if (idx == m_last) begin
        m_dw++;
      end else begin
        m_cs = (m_run >= LC) && (idx == 0);
        m_run++;
        m_dw   = 1;
        m_last = idx;
      end
    end
    if (clr) m_cnt = 0;
    else if (m_err && m_cnt < 255) m_cnt++;
  endtask

  task automatic tick(input logic [N-1:0] v, input bit clr);
    phaseIn = v;
`ifdef PHASE_DECODER_ERR_COUNT_EN
    errClr = clr;
`endif
    @(posedge clkIn);
    model_step(m_q, clr);
    m_q = v;
    #1;
    check("phaseIdx",   32'(phaseIdx),   32'(m_last));
    check("locked",     32'(locked),     32'(m_acq && m_run >= LC));
    check("cycleStart", 32'(cycleStart), 32'(m_cs));
    check("phaseErr",   32'(phaseErr),   32'(m_err));
`ifdef PHASE_DECODER_ERR_COUNT_EN
    check("errCount",   32'(errCount),   32'(m_cnt));
`endif
  endtask

  task automatic rotate(input int n, input int dwell);
    repeat (n) begin
      cur = (cur + N - 1) % N;
      repeat (dwell) tick(oh(cur), 1'b0);
    end
  endtask

  task automatic apply_reset();
    #2 reset = 1'b1;
    #2;
    check("rst_phaseIdx",   32'(phaseIdx),   32'd0);
    check("rst_locked",     32'(locked),     32'd0);
    check("rst_cycleStart", 32'(cycleStart), 32'd0);
    check("rst_phaseErr",   32'(phaseErr),   32'd0);
`ifdef PHASE_DECODER_ERR_COUNT_EN
    check("rst_errCount",   32'(errCount),   32'd0);
`endif
    @(posedge clkIn);
    #1 reset = 1'b0;
    model_reset();
  endtask

  initial begin
    reset   = 1'b1;
    phaseIn = '0;
`ifdef PHASE_DECODER_ERR_COUNT_EN
    errClr  = 1'b0;
`endif
    model_reset();
    cur = 0;
    apply_reset();

    // Dwell-1 rotation from 001: lock after the sixth edge.
    cur = 0;
    tick(oh(0), 1'b0);
    rotate(5, 1);
    check("lock_after_E5", 32'(locked),   32'd1);
    check("idx_after_E5",  32'(phaseIdx), 32'd2);
    rotate(6, 1);

    // Illegal two-hot vector while locked.
    tick(3'b011, 1'b0);
    tick(oh(cur), 1'b0);
    check("twohot_err",    32'(phaseErr), 32'd1);
    check("twohot_unlock", 32'(locked),   32'd0);
    check("twohot_idx",    32'(phaseIdx), 32'(cur));
    rotate(5, 1);
    check("relock_twohot", 32'(locked), 32'd1);

    // 001 then 010 is a skip.
    while (cur != 1) rotate(1, 1);
    tick(3'b001, 1'b0);
    tick(3'b010, 1'b0);
    tick(3'b010, 1'b0);
    check("skip_err",    32'(phaseErr), 32'd1);
    check("skip_unlock", 32'(locked),   32'd0);
    cur = 1;
    rotate(4, 1);
    check("skip_not_yet", 32'(locked), 32'd0);
    rotate(1, 1);
    check("skip_relock",  32'(locked), 32'd1);

    // Hold 100 for five samples: fifth one times out.
    while (cur != 0) rotate(1, 1);
    rotate(1, 5);
    check("hold_no_err_yet", 32'(phaseErr), 32'd0);
    check("hold_still_lock", 32'(locked),   32'd1);
    tick(oh(cur), 1'b0);
    check("timeout_err", 32'(phaseErr), 32'd1);

    // Dwell-2 rotation locks cleanly, then reset mid-stream.
    rotate(8, 2);
    check("dwell2_locked", 32'(locked), 32'd1);
    apply_reset();
    cur = 0;

    // Randomized rotation with occasional glitches, jumps, long holds and resets.
    for (int it = 0; it < 1500; it++) begin
      int r;
      r = $urandom_range(0, 199);
      if (r < 4) begin
        tick(N'($urandom), 1'b0);
      end else if (r < 7) begin
        cur = $urandom_range(0, N - 1);
        tick(oh(cur), 1'b0);
      end else if (r == 7) begin
        apply_reset();
      end else begin
        rotate(1, ($urandom_range(1, 100) < 95) ? $urandom_range(1, 3) : 5);
      end
    end

`ifdef PHASE_DECODER_ERR_COUNT_EN
    // Error counting and clear-over-error priority.
    tick(oh(cur), 1'b1);
    check("cnt_cleared", 32'(errCount), 32'd0);
    repeat (3) begin
      rotate(8, 1);
      tick(3'b011, 1'b0);
      tick(oh(cur), 1'b0);
    end
    check("cnt_three", 32'(errCount), 32'd3);
    rotate(8, 1);
    tick(3'b011, 1'b0);
    tick(oh(cur), 1'b1);
    check("cnt_clr_wins", 32'(errCount), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
